// File: rtl/jg3_pkg.sv
// Shared types and constants for the JG3 ABC input-conditioning stage.
package jg3_pkg;

  localparam int ABC_W                = 3;
  localparam int CNT_W                = 8;
  localparam int DEBOUNCE_CYCLES_DEF  = 4;
  localparam int SETTLE_MAX_DEF       = 255;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    HOLD   = 2'd2
  } jg3_state_e;

  function automatic logic all_quiet(input logic [ABC_W-1:0] quiet_vec);
    return &quiet_vec;
  endfunction

endpackage

// File: rtl/jg3_debounce_bit.sv
// One switch bit: two-flop synchroniser followed by a mismatch-count debouncer.
module jg3_debounce_bit
  import jg3_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic stable,
  output logic quiet
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             stable_q, stable_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // The flip happens on the same edge that would otherwise push cnt past its last value.
  always_comb begin
    sync1_d  = raw;
    sync2_d  = sync1_q;
    stable_d = stable_q;
    cnt_d    = cnt_q;
    if (sync2_q == stable_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      stable_d = ~stable_q;
      cnt_d    = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      stable_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  assign stable = stable_q;
  assign quiet  = (cnt_q == '0);

endmodule

// File: rtl/jg3_abc_sampler.sv
// Debounced 3-bit ABC switch sampler: a request edge captures a settled code or times out.
module jg3_abc_sampler
  import jg3_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int SETTLE_MAX      = SETTLE_MAX_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [ABC_W-1:0] raw_abc,
  input  logic             sample_req,
  output logic [ABC_W-1:0] abc,
  output logic             abc_valid,
  output logic             sample_err,
  output logic             busy
);

  localparam logic [CNT_W-1:0] TMR_LAST = CNT_W'(SETTLE_MAX - 1);

  logic [ABC_W-1:0] stable_abc;
  logic [ABC_W-1:0] quiet_abc;

  for (genvar g = 0; g < ABC_W; g++) begin : g_bit
    jg3_debounce_bit #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db (
      .clk   (clk),
      .rst_n (rst_n),
      .raw   (raw_abc[g]),
      .stable(stable_abc[g]),
      .quiet (quiet_abc[g])
    );
  end

  logic             req_s1_q, req_s1_d;
  logic             req_s2_q, req_s2_d;
  logic             req_dly_q, req_dly_d;
  logic             req_rise;
  jg3_state_e       state_q, state_d;
  logic [CNT_W-1:0] timer_q, timer_d;
  logic [ABC_W-1:0] abc_q, abc_d;
  logic             valid_q, valid_d;
  logic             err_q, err_d;
  logic             busy_q, busy_d;

  assign req_rise = req_s2_q & ~req_dly_q;

  // abc_valid and sample_err are single-cycle strobes with no backpressure;
  // abc holds its last captured value between strobes and only changes with abc_valid.
  always_comb begin
    req_s1_d  = sample_req;
    req_s2_d  = req_s1_q;
    req_dly_d = req_s2_q;
    state_d   = state_q;
    timer_d   = timer_q;
    abc_d     = abc_q;
    valid_d   = 1'b0;
    err_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_rise) begin
          state_d = SETTLE;
          timer_d = '0;
        end
      end
      SETTLE: begin
        if (all_quiet(quiet_abc)) begin
          abc_d   = stable_abc;
          valid_d = 1'b1;
          state_d = HOLD;
        end else if (timer_q == TMR_LAST) begin
          err_d   = 1'b1;
          state_d = HOLD;
        end else begin
          timer_d = timer_q + CNT_W'(1);
        end
      end
      HOLD: begin
        // Wait for the button to be let go so a held press captures only once.
        if (!req_s2_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_s1_q  <= 1'b0;
      req_s2_q  <= 1'b0;
      req_dly_q <= 1'b0;
      state_q   <= IDLE;
      timer_q   <= '0;
      abc_q     <= '0;
      valid_q   <= 1'b0;
      err_q     <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      req_s1_q  <= req_s1_d;
      req_s2_q  <= req_s2_d;
      req_dly_q <= req_dly_d;
      state_q   <= state_d;
      timer_q   <= timer_d;
      abc_q     <= abc_d;
      valid_q   <= valid_d;
      err_q     <= err_d;
      busy_q    <= busy_d;
    end
  end

  assign abc        = abc_q;
  assign abc_valid  = valid_q;
  assign sample_err = err_q;
  assign busy       = busy_q;

endmodule

// File: doc/jg3_abc_sampler.md
# jg3_abc_sampler

Input-conditioning stage that sits directly upstream of the JG3 judge logic and supplies its 3-bit ABC code. Three raw switch inputs are synchronised and debounced per bit. A sample request then captures a settled code into a registered `abc` output, marked by a one-cycle `abc_valid` pulse. If the inputs never settle, the block reports a timeout instead of delivering a code.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 4: consecutive mismatch cycles required before a debounced bit flips; legal range 2..255.
- `SETTLE_MAX`, default 255: maximum number of cycles spent in SETTLE before the capture is abandoned; legal range 1..255.

Ports:
- `clk` input 1: single clock. All flops are rising-edge.
- `rst_n` input 1: reset, asynchronous and active-low.
- `raw_abc` input 3: asynchronous switch levels; bit 2 = A, bit 0 = C.
- `sample_req` input 1: asynchronous request level (button).
- `abc` output 3: captured code; reset value 3'b000.
- `abc_valid` output 1: one-cycle pulse when `abc` is newly captured; reset 0.
- `sample_err` output 1: one-cycle pulse when SETTLE times out; reset 0.
- `busy` output 1: high whenever the FSM is not IDLE; reset 0.

## Operation
- Every bit of `raw_abc`, and `sample_req`, passes through a two-flop synchroniser. All synchroniser flops reset to 0.
- Debounce, per ABC bit:
  - `stable` resets to 0 and `cnt` resets to 0.
  - If the synchronised value equals `stable`, `cnt` returns to 0.
  - Otherwise `cnt` increments each cycle.
  - When `cnt` equals `DEBOUNCE_CYCLES-1` and the mismatch is still present, `stable` flips and `cnt` returns to 0 on that edge.
  - A bit is "quiet" in a cycle when its `cnt` is 0.
- Request edge: a third flop delays the synchronised request. `req_rise` = synced & ~delayed.
- FSM states: IDLE, SETTLE, HOLD. Reset state is IDLE.
  - IDLE -> SETTLE on `req_rise`. The settle timer clears to 0.
  - SETTLE, all three bits quiet: on that edge `abc` <= stable vector, `abc_valid` is high for the following cycle, and the FSM moves to HOLD.
  - SETTLE, not all quiet: the timer increments. When the timer reaches `SETTLE_MAX-1` without a capture, `sample_err` pulses, `abc` keeps its old value, and the FSM moves to HOLD.
  - HOLD -> IDLE when the synchronised request is 0. A held button therefore yields exactly one capture.
- `req_rise` is ignored outside IDLE.
- `abc` changes only on a capture. Downstream must qualify `abc` with `abc_valid`, or use it after the first valid.
- Reset asserted mid-operation clears all state immediately: outputs return to reset values and the FSM returns to IDLE. No pulse is emitted on reset release.

## Timing
- Raw bit change set up before edge 1:
  - synchroniser output changes at edge 2;
  - `stable` flips at edge `DEBOUNCE_CYCLES`+2 (edge 6 at default).
- Bounce shorter than `DEBOUNCE_CYCLES` consecutive cycles never reaches `stable`.
- Request rising level set up before edge 1, with inputs already quiet:
  - `req_rise` is true in the cycle after edge 2;
  - SETTLE is entered at edge 3;
  - capture occurs at edge 4, and `abc_valid` is high between edges 4 and 5.
- `busy` rises at edge 3.
- Worst-case capture-or-error latency from the request edge is 3 + `SETTLE_MAX` edges.
- Simultaneous events:
  - a bit flipping on the capture edge is not yet included; `abc` takes the pre-edge `stable` value;
  - request release during SETTLE does not abort the capture.

## Structure
- Package `jg3_pkg` holds:
  - `ABC_W` = 3;
  - the state typedef (IDLE, SETTLE, HOLD);
  - default parameter constants.
- Sub-module `jg3_debounce_bit` contains the synchroniser, the counter and the stable flop, and exports `stable` and `quiet`. The top level instantiates it three times.
- Request synchroniser, edge detect, FSM, settle timer and output registers live in the top level.

## Test plan
- Reset with `raw_abc`=3'b101 held -> `abc`=000, `abc_valid`=0, `busy`=0 during reset. After release, `stable`=101 at edge 6. A request then produces `abc`=101 with `abc_valid` between edges 4 and 5 of the request.
- Bit 0 toggling every 2 cycles for 20 cycles, `DEBOUNCE_CYCLES`=4 -> `stable` bit 0 never changes and no `abc_valid` pulse occurs.
- Request during continuous bouncing, `SETTLE_MAX`=8 -> `sample_err` pulses once, `abc` is unchanged, and the FSM goes to HOLD then IDLE after release.
- Request held 100 cycles, then `raw_abc` changes to 3'b000 -> exactly one `abc_valid` pulse. A second press then captures 000.
- `rst_n` pulsed low while in SETTLE -> immediate IDLE, all outputs 0, no pulse after release.
